mem_responder: RTL and testbench

- Memory-side responder for the 8-bit CPU bus. It answers the CPU's read and write strobes on the 16-bit address / 8-bit data interface.
- Contains three things:
  - a synchronous RAM of 2**ADDR_BITS bytes;
  - two memory-mapped I/O registers: a switch input and an LED output;
  - a programming port that preloads code before the CPU runs.
- Adds a configurable wait-state handshake (ready) so bus timing can be stretched. Sits between the cpu top level and the board I/O.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_ram.sv | 23 ++
 rtl/mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-bus memory responder: FSM states, I/O map and address decode.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RG_RAM,
    RG_SW,
    RG_LED,
    RG_NONE
  } region_e;

  localparam logic [15:0] IO_SW_OFS       = 16'd0;
  localparam logic [15:0] IO_LED_OFS      = 16'd1;
  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

  function automatic region_e decode(input logic [15:0] a, input int unsigned abits,
                                     input logic [15:0] base);
    if ((a >> abits) == 16'd0) return RG_RAM;
    if (a == base + IO_SW_OFS) return RG_SW;
    if (a == base + IO_LED_OFS) return RG_LED;
    return RG_NONE;
  endfunction

endpackage

// File: rtl/mem_ram.sv
// Single-port synchronous RAM, read-during-write returns the old word, no reset.
module mem_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[a] <= d;
    rd_q <= mem[a];
  end

  assign q = rd_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 8-bit CPU bus: RAM, switch/LED registers, preload port
// and a wait-state handshake producing a one-cycle ready pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] IO_BASE     = IO_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          addr,
  input  logic [7:0]           wdata,
  input  logic                 read,
  input  logic                 write,
  output logic [7:0]           rdata,
  output logic                 ready,
  output logic                 bus_err,
  input  logic [7:0]           sw_in,
  output logic [7:0]           led_out,
  input  logic                 prog_we,
  input  logic [ADDR_BITS-1:0] prog_addr,
  input  logic [7:0]           prog_data
);

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic           wr_q, wr_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [7:0]     led_q, led_d;
  logic [7:0]     io_q, io_d;

  logic [15:0]    acc_addr;
  logic [7:0]     acc_wdata;
  logic           acc_wr;
  logic           enter_resp;
  logic           ram_we;
  logic [ADDR_BITS-1:0] ram_a;
  logic [7:0]     ram_d;
  logic [7:0]     ram_q;
  logic [7:0]     resp_data;

  // With no wait states the access completes on its sampling edge, so the live bus is used.
  always_comb begin
    acc_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
    acc_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;
    acc_wr    = (state_q == ST_IDLE) ? write : wr_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    led_d      = led_q;
    io_d       = io_q;
    enter_resp = 1'b0;
    ram_we     = 1'b0;
    ram_a      = acc_addr[ADDR_BITS-1:0];
    ram_d      = acc_wdata;

    unique case (state_q)
      ST_IDLE: begin
        if (prog_we) begin
          ram_we = 1'b1;
          ram_a  = prog_addr;
          ram_d  = prog_data;
        end else if (read && write) begin
          err_d = 1'b1;
        end else if (read || write) begin
          addr_d  = addr;
          wdata_d = wdata;
          wr_d    = write;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end else begin
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) enter_resp = 1'b1;
        else               cnt_d = cnt_q - 4'd1;
      end
      ST_RESP: begin
        state_d = ST_HOLD;
        if (!wr_q) rdata_d = resp_data;
      end
      ST_HOLD: begin
        if (!read && !write) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      state_d = ST_RESP;
      cnt_d   = 4'd0;
      unique case (decode(acc_addr, ADDR_BITS, IO_BASE))
        RG_RAM:  ram_we = acc_wr && !rst;
        RG_SW:   io_d   = sw_in;
        RG_LED: begin
          io_d = led_q;
          if (acc_wr) led_d = acc_wdata;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      led_q   <= '0;
      io_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      led_q   <= led_d;
      io_q    <= io_d;
    end
  end

  mem_ram #(.AW(ADDR_BITS), .DW(8)) u_ram (
    .clk (clk),
    .we  (ram_we),
    .a   (ram_a),
    .d   (ram_d),
    .q   (ram_q)
  );

  // RAM data arrives on the RESP-entry edge; it is presented live during RESP and held after.
  always_comb begin
    unique case (decode(addr_q, ADDR_BITS, IO_BASE))
      RG_RAM:  resp_data = ram_q;
      RG_SW,
      RG_LED:  resp_data = io_q;
      default: resp_data = 8'h00;
    endcase
  end

  assign rdata   = (state_q == ST_RESP && !wr_q) ? resp_data : rdata_q;
  assign ready   = (state_q == ST_RESP);
  assign bus_err = err_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instances with WAIT_CYCLES = 1, 3 and 0.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [3];
  logic [15:0] addr    [3];
  logic [7:0]  wdata   [3];
  logic        rd_s    [3];
  logic        wr_s    [3];
  logic [7:0]  rdata   [3];
  logic        ready   [3];
  logic        bus_err [3];
  logic [7:0]  sw      [3];
  logic [7:0]  led     [3];
  logic        pwe     [3];
  logic [7:0]  paddr   [3];
  logic [7:0]  pdata   [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .ADDR_BITS   (8),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
      .IO_BASE     (16'hFF00)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .read      (rd_s[g]),
      .write     (wr_s[g]),
      .rdata     (rdata[g]),
      .ready     (ready[g]),
      .bus_err   (bus_err[g]),
      .sw_in     (sw[g]),
      .led_out   (led[g]),
      .prog_we   (pwe[g]),
      .prog_addr (paddr[g]),
      .prog_data (pdata[g])
    );
  end

  task automatic preload(input int k, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pwe[k] = 1'b1; paddr[k] = a; pdata[k] = d;
    @(negedge clk);
    pwe[k] = 1'b0;
  endtask

  // Runs one CPU access; lat counts edges from the sampling edge (=1) to the first ready.
  task automatic access(input int k, input logic w, input logic [15:0] a, input logic [7:0] d,
                        input int hold, output logic [7:0] rd, output logic [7:0] ld,
                        output int lat, output int pulses);
    @(negedge clk);
    addr[k] = a; wdata[k] = d; rd_s[k] = !w; wr_s[k] = w;
    lat = 0; pulses = 0; rd = 8'hxx; ld = 8'hxx;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (ready[k]) begin
        lat = i; pulses++; rd = rdata[k]; ld = led[k];
      end
    end
    for (int i = 0; i <= hold; i++) begin
      @(posedge clk); #1;
      if (ready[k]) pulses++;
    end
    @(negedge clk);
    rd_s[k] = 1'b0; wr_s[k] = 1'b0;
    @(posedge clk); #1;
    if (ready[k]) pulses++;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; addr[k] = '0; wdata[k] = '0; rd_s[k] = 1'b0; wr_s[k] = 1'b0;
      sw[k] = 8'h00; pwe[k] = 1'b0; paddr[k] = '0; pdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (rdata[k] !== 8'h00) begin errors++; $display("FAIL reset_rdata[%0d] got %h want 00", k, rdata[k]); end
      checks++; if (ready[k] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d] got %b want 0", k, ready[k]); end
      checks++; if (bus_err[k] !== 1'b0) begin errors++; $display("FAIL reset_bus_err[%0d] got %b want 0", k, bus_err[k]); end
      checks++; if (led[k] !== 8'h00) begin errors++; $display("FAIL reset_led[%0d] got %h want 00", k, led[k]); end
      rst[k] = 1'b0;
    end
  endtask

  task automatic test_preload;
    logic [7:0] rd, ld; int lat, pulses;
    preload(0, 8'h10, 8'hA5);
    access(0, 1'b0, 16'h0010, 8'h00, 0, rd, ld, lat, pulses);
    checks++; if (lat !== 2) begin errors++; $display("FAIL preload_latency got %0d want 2", lat); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL preload_pulses got %0d want 1", pulses); end
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL preload_rdata got %h want a5", rd); end
    checks++; if (bus_err[0] !== 1'b0) begin errors++; $display("FAIL preload_bus_err got %b want 0", bus_err[0]); end
  endtask

  task automatic test_write_read;
    logic [7:0] rd, ld; int lat, pulses;
    access(0, 1'b1, 16'h0020, 8'h3C, 5, rd, ld, lat, pulses);
    checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency got %0d want 2", lat); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL held_strobe_pulses got %0d want 1", pulses); end
    checks++; if (rdata[0] !== 8'hA5) begin errors++; $display("FAIL write_keeps_rdata got %h want a5", rdata[0]); end
    access(0, 1'b0, 16'h0020, 8'h00, 0, rd, ld, lat, pulses);
    checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL readback_rdata got %h want 3c", rd); end
    checks++; if (rdata[0] !== 8'h3C) begin errors++; $display("FAIL readback_held got %h want 3c", rdata[0]); end
  endtask

  task automatic test_io;
    logic [7:0] rd, ld; int lat, pulses;
    sw[0] = 8'h5A;
    access(0, 1'b0, 16'hFF00, 8'h00, 0, rd, ld, lat, pulses);
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL sw_read got %h want 5a", rd); end
    access(0, 1'b1, 16'hFF01, 8'hF0, 0, rd, ld, lat, pulses);
    checks++; if (ld !== 8'hF0) begin errors++; $display("FAIL led_at_resp got %h want f0", ld); end
    access(0, 1'b0, 16'hFF01, 8'h00, 0, rd, ld, lat, pulses);
    checks++; if (rd !== 8'hF0) begin errors++; $display("FAIL led_read got %h want f0", rd); end
    access(0, 1'b1, 16'hFF00, 8'h12, 0, rd, ld, lat, pulses);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL sw_write_pulses got %0d want 1", pulses); end
    checks++; if (led[0] !== 8'hF0) begin errors++; $display("FAIL sw_write_led got %h want f0", led[0]); end
    checks++; if (bus_err[0] !== 1'b0) begin errors++; $display("FAIL sw_write_bus_err got %b want 0", bus_err[0]); end
  endtask

  task automatic test_unmapped;
    logic [7:0] rd, ld; int lat, pulses;
    access(0, 1'b0, 16'h1234, 8'h00, 0, rd, ld, lat, pulses);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL unmapped_rdata got %h want 00", rd); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL unmapped_pulses got %0d want 1", pulses); end
    checks++; if (bus_err[0] !== 1'b1) begin errors++; $display("FAIL unmapped_bus_err got %b want 1", bus_err[0]); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus_err[0] !== 1'b1) begin errors++; $display("FAIL bus_err_sticky got %b want 1", bus_err[0]); end
  endtask

  task automatic test_collision;
    @(negedge clk);
    pwe[2] = 1'b1; paddr[2] = 8'h40; pdata[2] = 8'h99;
    addr[2] = 16'h0040; rd_s[2] = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready[2] !== 1'b0) begin errors++; $display("FAIL collision_preload_edge ready got %b want 0", ready[2]); end
    @(negedge clk);
    pwe[2] = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready[2] !== 1'b1) begin errors++; $display("FAIL collision_ready got %b want 1", ready[2]); end
    checks++; if (rdata[2] !== 8'h99) begin errors++; $display("FAIL collision_rdata got %h want 99", rdata[2]); end
    @(posedge clk); #1;
    checks++; if (ready[2] !== 1'b0) begin errors++; $display("FAIL collision_single_pulse got %b want 0", ready[2]); end
    @(negedge clk);
    rd_s[2] = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_both_strobes;
    int pulses = 0;
    @(negedge clk);
    addr[2] = 16'h0050; rd_s[2] = 1'b1; wr_s[2] = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready[2]) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL both_strobes_pulses got %0d want 0", pulses); end
    checks++; if (bus_err[2] !== 1'b1) begin errors++; $display("FAIL both_strobes_bus_err got %b want 1", bus_err[2]); end
    @(negedge clk);
    rd_s[2] = 1'b0; wr_s[2] = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid_wait;
    logic [7:0] rd, ld; int lat, pulses;
    preload(1, 8'h30, 8'h11);
    access(1, 1'b1, 16'hFF01, 8'hAB, 0, rd, ld, lat, pulses);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wait3_latency got %0d want 4", lat); end
    checks++; if (led[1] !== 8'hAB) begin errors++; $display("FAIL wait3_led got %h want ab", led[1]); end
    @(negedge clk);
    addr[1] = 16'h0030; wdata[1] = 8'h77; wr_s[1] = 1'b1;
    pulses = 0;
    @(posedge clk); #1;
    if (ready[1]) pulses++;
    @(posedge clk); #1;
    if (ready[1]) pulses++;
    @(negedge clk);
    rst[1] = 1'b1; wr_s[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready[1]) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pulses got %0d want 0", pulses); end
    checks++; if (led[1] !== 8'h00) begin errors++; $display("FAIL abort_led got %h want 00", led[1]); end
    checks++; if (g_dut[1].u_dut.state_q !== ST_IDLE) begin errors++; $display("FAIL abort_state got %0d want 0", g_dut[1].u_dut.state_q); end
    access(1, 1'b0, 16'h0030, 8'h00, 0, rd, ld, lat, pulses);
    checks++; if (rd !== 8'h11) begin errors++; $display("FAIL abort_ram_kept got %h want 11", rd); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL abort_read_latency got %0d want 4", lat); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_write_read();
    test_io();
    test_unmapped();
    test_collision();
    test_both_strobes();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
